// File: rtl/rom_dma_mc_ctrl.sv
// Multi-channel ROM DMA: round-robin issue of one ROM read per cycle, tagged
// read pipeline, credit-protected output FIFO and per-channel completion.
module rom_dma_mc_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int ROM_ADDR_WIDTH = 12,
  parameter int ROM_DATA_WIDTH = 8,
  parameter int ROM_RD_LAT     = 2,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_vld,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [ROM_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ROM_ADDR_WIDTH:0]   cfg_num_bytes,
  output logic                      cfg_ready,
  output logic [ROM_ADDR_WIDTH-1:0] rom_rd_addr,
  output logic                      CE_bar,
  output logic                      OE_bar,
  output logic                      WE_bar,
  input  logic [ROM_DATA_WIDTH-1:0] rom_rd_data,
  output logic                      out_vld,
  output logic [ROM_DATA_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic [NUM_CH-1:0]         ch_done,
  output logic                      all_done
);
  localparam int AW    = ROM_ADDR_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROM_DATA_WIDTH + CH_W + 1;
  localparam logic [AW:0]   ONE_R = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {CH_IDLE, CH_ISSUE, CH_DRAIN} ch_state_e;

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [AW-1:0]     base_q  [NUM_CH];
  logic [AW-1:0]     base_d  [NUM_CH];
  logic [AW-1:0]     offs_q  [NUM_CH];
  logic [AW-1:0]     offs_d  [NUM_CH];
  logic [AW:0]       rem_q   [NUM_CH];
  logic [AW:0]       rem_d   [NUM_CH];
  logic [NUM_CH-1:0] done_q, done_d, zl_q, zl_d, idle_vec;
  logic [CH_W-1:0]   last_gnt_q, last_gnt_d;
  logic [AW-1:0]     addr_q, addr_d;

  logic [ROM_RD_LAT-1:0] pv_q, pv_d, plast_q, plast_d;
  logic [CH_W-1:0]       pch_q [ROM_RD_LAT];
  logic [CH_W-1:0]       pch_d [ROM_RD_LAT];

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            gnt, credit_ok, push, pop, cfg_acc;
  logic [CH_W-1:0] gnt_ch;
  logic [31:0]     occ;
  int              rr_c;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign idle_vec[gi] = (state_q[gi] == CH_IDLE);
    assign ch_busy[gi]  = ~idle_vec[gi];
  end

  assign cfg_ready = idle_vec[cfg_ch];
  assign cfg_acc   = cfg_vld & cfg_ready;
  assign out_vld   = (cnt_q != '0);
  assign pop       = out_vld & out_ready;
  assign push      = pv_q[ROM_RD_LAT-1];
  assign {out_data, out_ch, out_last} = fifo_mem[rd_ptr_q];

  // Credit counts every read still in the pipeline, so the FIFO can always absorb them.
  always_comb begin
    occ = 32'(cnt_q);
    for (int i = 0; i < ROM_RD_LAT; i++) occ = occ + 32'(pv_q[i]);
  end
  assign credit_ok = occ < 32'(FIFO_DEPTH);

  always_comb begin
    gnt    = 1'b0;
    gnt_ch = '0;
    rr_c   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      rr_c = (int'(last_gnt_q) + i) % NUM_CH;
      if (!gnt && credit_ok && state_q[rr_c] == CH_ISSUE) begin
        gnt    = 1'b1;
        gnt_ch = CH_W'(rr_c);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      base_d[c]  = base_q[c];
      offs_d[c]  = offs_q[c];
      rem_d[c]   = rem_q[c];
    end
    done_d     = '0;
    zl_d       = '0;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    if (cfg_acc) begin
      if (cfg_num_bytes == '0) begin
        done_d[cfg_ch] = 1'b1;
        zl_d[cfg_ch]   = 1'b1;
      end else begin
        state_d[cfg_ch] = CH_ISSUE;
        base_d[cfg_ch]  = cfg_base_addr;
        offs_d[cfg_ch]  = '0;
        rem_d[cfg_ch]   = cfg_num_bytes;
      end
    end
    if (gnt) begin
      addr_d          = base_q[gnt_ch] + offs_q[gnt_ch];
      offs_d[gnt_ch]  = offs_q[gnt_ch] + ONE_A;
      rem_d[gnt_ch]   = rem_q[gnt_ch] - ONE_R;
      last_gnt_d      = gnt_ch;
      if (rem_q[gnt_ch] == ONE_R) state_d[gnt_ch] = CH_DRAIN;
    end
    if (pop && out_last) begin
      state_d[out_ch] = CH_IDLE;
      done_d[out_ch]  = 1'b1;
    end
  end

  always_comb begin
    pv_d[0]    = gnt;
    pch_d[0]   = gnt_ch;
    plast_d[0] = gnt & (rem_q[gnt_ch] == ONE_R);
    for (int i = 1; i < ROM_RD_LAT; i++) begin
      pv_d[i]    = pv_q[i-1];
      pch_d[i]   = pch_q[i-1];
      plast_d[i] = plast_q[i-1];
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Address output holds its last value between grants.
  assign rom_rd_addr = addr_d;
  assign CE_bar      = ~gnt;
  assign OE_bar      = ~gnt;
  assign WE_bar      = 1'b1;
  assign ch_done     = done_q;
  assign all_done    = ~|ch_busy & (cnt_q == '0) & ~|pv_q & ~|zl_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {rom_rd_data, pch_q[ROM_RD_LAT-1], plast_q[ROM_RD_LAT-1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= CH_IDLE;
        base_q[c]  <= '0;
        offs_q[c]  <= '0;
        rem_q[c]   <= '0;
      end
      for (int i = 0; i < ROM_RD_LAT; i++) pch_q[i] <= '0;
      done_q     <= '0;
      zl_q       <= '0;
      last_gnt_q <= '0;
      addr_q     <= '0;
      pv_q       <= '0;
      plast_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        base_q[c]  <= base_d[c];
        offs_q[c]  <= offs_d[c];
        rem_q[c]   <= rem_d[c];
      end
      for (int i = 0; i < ROM_RD_LAT; i++) pch_q[i] <= pch_d[i];
      done_q     <= done_d;
      zl_q       <= zl_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      pv_q       <= pv_d;
      plast_q    <= plast_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rom_dma_mc_ctrl.sv
// Bench for rom_dma_mc_ctrl: async ROM model (ROM[a]=a[7:0]), queue-level
// reference model checked every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_rom_dma_mc_ctrl;
  localparam int NUM_CH = 4, CH_W = 2, AW = 12, DW = 8, LAT = 2, DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n, cfg_vld, cfg_ready, CE_bar, OE_bar, WE_bar, out_vld, out_last, out_ready, all_done;
  logic [CH_W-1:0] cfg_ch, out_ch;
  logic [AW-1:0] cfg_base_addr, rom_rd_addr;
  logic [AW:0] cfg_num_bytes;
  logic [DW-1:0] rom_rd_data, out_data;
  logic [NUM_CH-1:0] ch_busy, ch_done;

  always #5 clk = ~clk;

  rom_dma_mc_ctrl #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ROM_ADDR_WIDTH(AW), .ROM_DATA_WIDTH(DW),
                    .ROM_RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_vld(cfg_vld), .cfg_ch(cfg_ch),
    .cfg_base_addr(cfg_base_addr), .cfg_num_bytes(cfg_num_bytes), .cfg_ready(cfg_ready),
    .rom_rd_addr(rom_rd_addr), .CE_bar(CE_bar), .OE_bar(OE_bar), .WE_bar(WE_bar),
    .rom_rd_data(rom_rd_data), .out_vld(out_vld), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .out_ready(out_ready), .ch_busy(ch_busy), .ch_done(ch_done),
    .all_done(all_done));

  int total = 0, bad = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Async ROM: data for the address seen LAT cycles earlier.
  logic [AW-1:0] hist [LAT];
  logic [AW-1:0] cur_addr;
  always @(posedge clk) begin
    hist[0] <= cur_addr;
    for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
  end
  assign rom_rd_data = hist[LAT-1][7:0];

  typedef struct { int ch; int data; bit last; int t; } ent_t;
  ent_t fq[$];
  ent_t pop_log[$];
  int   issue_log[$];
  int   exp_addr [NUM_CH][$];
  bit   busy_m [NUM_CH];
  bit [NUM_CH-1:0] done_cur = '0, zl_cur = '0, busy_v, done_nxt, zl_nxt;
  int   last_g = 0, cyc = 0, g, first_issue = -1, first_vld = -1;
  int   done_cnt [NUM_CH];
  bit   chk_on = 1'b0, exp_vld;
  ent_t e;

  always @(negedge clk) begin
    cur_addr = rom_rd_addr;
    cyc++;
    if (chk_on) begin
      for (int c = 0; c < NUM_CH; c++) begin
        busy_v[c] = busy_m[c];
        if (ch_done[c]) done_cnt[c]++;
      end
      chk("ch_busy", ch_busy, busy_v);
      chk("ch_done", ch_done, done_cur);
      chk("all_done", all_done, (busy_v == '0) && fq.size() == 0 && zl_cur == '0);
      chk("cfg_ready", cfg_ready, !busy_m[cfg_ch]);
      chk("WE_bar", WE_bar, 1);
      chk("OE_bar", OE_bar, CE_bar);
      // Expected grant: round-robin after the last grant, gated by outstanding reads.
      g = -1;
      if (fq.size() < DEPTH)
        for (int i = 1; i <= NUM_CH; i++) begin
          int c;
          c = (last_g + i) % NUM_CH;
          if (g < 0 && busy_m[c] && exp_addr[c].size() > 0) g = c;
        end
      chk("issue", !CE_bar, g >= 0);
      if (!CE_bar) begin
        issue_log.push_back(int'(rom_rd_addr));
        if (first_issue < 0) first_issue = cyc;
        if (g >= 0) chk("rom_rd_addr", rom_rd_addr, exp_addr[g][0]);
      end
      exp_vld = fq.size() > 0 && (fq[0].t + LAT + 1 <= cyc);
      chk("out_vld", out_vld, exp_vld);
      if (out_vld && first_vld < 0) first_vld = cyc;
      if (exp_vld) begin
        chk("out_data", out_data, fq[0].data);
        chk("out_ch", out_ch, fq[0].ch);
        chk("out_last", out_last, fq[0].last);
      end
      if (out_vld && out_ready) begin
        e.ch = int'(out_ch); e.data = int'(out_data); e.last = out_last; e.t = cyc;
        pop_log.push_back(e);
        $display("pop  t=%0d ch=%0d data=%02h last=%0b", cyc, out_ch, out_data, out_last);
      end
      if (!reset_n) begin
        fq.delete();
        for (int c = 0; c < NUM_CH; c++) begin exp_addr[c].delete(); busy_m[c] = 1'b0; end
        done_cur = '0; zl_cur = '0; last_g = 0;
      end else begin
        done_nxt = '0; zl_nxt = '0;
        if (exp_vld && out_ready) begin
          e = fq.pop_front();
          if (e.last) begin busy_m[e.ch] = 1'b0; done_nxt[e.ch] = 1'b1; end
        end
        if (g >= 0) begin
          e.ch = g; e.data = exp_addr[g].pop_front() & 'hFF;
          e.last = (exp_addr[g].size() == 0); e.t = cyc;
          fq.push_back(e);
          last_g = g;
        end
        if (cfg_vld && !busy_m[cfg_ch]) begin
          $display("cfg  t=%0d ch=%0d base=%03h len=%0d", cyc, cfg_ch, cfg_base_addr, cfg_num_bytes);
          if (cfg_num_bytes == 0) begin
            done_nxt[cfg_ch] = 1'b1; zl_nxt[cfg_ch] = 1'b1;
          end else begin
            busy_m[cfg_ch] = 1'b1;
            for (int i = 0; i < int'(cfg_num_bytes); i++)
              exp_addr[cfg_ch].push_back((int'(cfg_base_addr) + i) % (1 << AW));
          end
        end
        done_cur = done_nxt; zl_cur = zl_nxt;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input int ch, input int base, input int len);
    cfg_vld = 1'b1; cfg_ch = CH_W'(ch); cfg_base_addr = AW'(base); cfg_num_bytes = (AW+1)'(len);
    step();
    cfg_vld = 1'b0;
  endtask

  task automatic clear_logs();
    pop_log.delete(); issue_log.delete();
    first_issue = -1; first_vld = -1;
    for (int c = 0; c < NUM_CH; c++) done_cnt[c] = 0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n;
    n = 0;
    step(); step();
    while (!(all_done && fq.size() == 0) && n < budget) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("idle_reached", n < budget, 1);
    out_ready = 1'b1;
    step();
  endtask

  task automatic chk_pop(input string nm, input int i, input int d, input int c, input int l);
    chk({nm, "_data"}, pop_log[i].data, d);
    chk({nm, "_ch"}, pop_log[i].ch, c);
    chk({nm, "_last"}, pop_log[i].last, l);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_CE_bar"}, CE_bar, 1);
    chk({nm, "_OE_bar"}, OE_bar, 1);
    chk({nm, "_WE_bar"}, WE_bar, 1);
    chk({nm, "_addr"}, rom_rd_addr, 0);
    chk({nm, "_out_vld"}, out_vld, 0);
    chk({nm, "_ch_busy"}, ch_busy, 0);
    chk({nm, "_ch_done"}, ch_done, 0);
    chk({nm, "_all_done"}, all_done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t2_d[6] = '{'h20, 'h40, 'h21, 'h41, 'h22, 'h42};
    int t2_c[6] = '{1, 2, 1, 2, 1, 2};
    int t2_l[6] = '{0, 0, 0, 0, 1, 1};
    int t4_a[4] = '{'hFFE, 'hFFF, 'h000, 'h001};
    int t4_d[4] = '{'hFE, 'hFF, 'h00, 'h01};
    int errs;
    reset_n = 1'b0; cfg_vld = 1'b0; cfg_ch = '0; cfg_base_addr = '0; cfg_num_bytes = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset_n = 1'b1; chk_on = 1'b1;

    // 1: single channel, 4 bytes
    clear_logs();
    cfg(0, 'h010, 4);
    wait_idle(100, 1'b0);
    chk("t1_count", pop_log.size(), 4);
    if (pop_log.size() == 4)
      for (int i = 0; i < 4; i++) chk_pop("t1", i, 'h10 + i, 0, i == 3);
    chk("t1_latency", first_vld - first_issue, 3);
    chk("t1_done0", done_cnt[0], 1);

    // 2: two channels interleave round-robin
    clear_logs();
    cfg(1, 'h020, 3);
    cfg(2, 'h040, 3);
    wait_idle(100, 1'b0);
    chk("t2_count", pop_log.size(), 6);
    if (pop_log.size() == 6)
      for (int i = 0; i < 6; i++) chk_pop("t2", i, t2_d[i], t2_c[i], t2_l[i]);
    chk("t2_done1", done_cnt[1], 1);
    chk("t2_done2", done_cnt[2], 1);

    // 3: backpressure stops issue at FIFO_DEPTH outstanding reads
    clear_logs();
    out_ready = 1'b0;
    cfg(0, 'h100, 40);
    repeat (40) step();
    chk("t3_stalled_issues", issue_log.size(), 16);
    chk("t3_CE_bar", CE_bar, 1);
    chk("t3_out_vld", out_vld, 1);
    wait_idle(2000, 1'b1);
    chk("t3_issues", issue_log.size(), 40);
    chk("t3_count", pop_log.size(), 40);
    errs = 0;
    if (pop_log.size() == 40)
      for (int i = 0; i < 40; i++)
        if (pop_log[i].data != i || pop_log[i].ch != 0 || pop_log[i].last != (i == 39)) errs++;
    chk("t3_order_errs", errs, 0);

    // 4: address wrap
    clear_logs();
    cfg(3, 'hFFE, 4);
    wait_idle(100, 1'b0);
    chk("t4_issues", issue_log.size(), 4);
    chk("t4_count", pop_log.size(), 4);
    if (issue_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("t4_addr", issue_log[i], t4_a[i]);
    if (pop_log.size() == 4)
      for (int i = 0; i < 4; i++) chk_pop("t4", i, t4_d[i], 3, i == 3);

    // 5: reconfig of busy channel ignored; zero-length transfer
    clear_logs();
    out_ready = 1'b0;
    cfg(0, 'h200, 8);
    step(); step();
    cfg_vld = 1'b1; cfg_ch = 2'd0; cfg_base_addr = 12'h300; cfg_num_bytes = 13'd5;
    #1;
    chk("t5_cfg_ready_busy", cfg_ready, 0);
    step();
    cfg_vld = 1'b0;
    cfg(1, 'h000, 0);
    chk("t5_zl_done", ch_done, 4'b0010);
    chk("t5_zl_busy", ch_busy[1], 0);
    out_ready = 1'b1;
    wait_idle(200, 1'b0);
    chk("t5_issues", issue_log.size(), 8);
    if (issue_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("t5_addr", issue_log[i], 'h200 + i);
    chk("t5_count", pop_log.size(), 8);
    if (pop_log.size() == 8)
      for (int i = 0; i < 8; i++) chk_pop("t5", i, i, 0, i == 7);
    chk("t5_done0", done_cnt[0], 1);
    chk("t5_done1", done_cnt[1], 1);

    // 6: reset mid-transfer, then clean run
    clear_logs();
    cfg(2, 'h080, 20);
    repeat (8) step();
    reset_n = 1'b0;
    step();
    chk_reset_vals("t6_rst");
    reset_n = 1'b1;
    clear_logs();
    cfg(0, 'h050, 3);
    wait_idle(100, 1'b0);
    chk("t6_count", pop_log.size(), 3);
    if (pop_log.size() == 3)
      for (int i = 0; i < 3; i++) chk_pop("t6", i, 'h50 + i, 0, i == 2);
    chk("t6_done2", done_cnt[2], 0);
    chk("t6_done0", done_cnt[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
